// File: rtl/tracer_pkg.sv
// tracer_pkg: shared types, record layout and ASCII helpers for the bus tracer
package tracer_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, EMIT, WAIT} state_t;
  localparam int REC_W = 26;
  localparam int DB_LSB = 0;
  localparam int AB_LSB = 8;
  localparam int SYNC_BIT = 24;
  localparam int RW_BIT = 25;
  localparam logic [7:0] ZERO = 8'h30;
  localparam logic [7:0] A = 8'h41;
  localparam logic [7:0] S = 8'h53;
  localparam logic [7:0] R = 8'h52;
  localparam logic [7:0] W = 8'h57;
  localparam logic [7:0] SP = 8'h20;
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    return n < 4'd10 ? ZERO + {4'h0, n} : A + {4'h0, n} - 8'd10;
  endfunction
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous FIFO with concurrent push/pop and registered occupancy
module trace_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_L,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign rdata = mem[rp];
  // pointers wrap naturally at DEPTH; count tracks net push/pop
  always_ff @(posedge clk)
    if (!rst_L) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  // storage array, written only on an accepted push
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= wdata;
endmodule

// File: rtl/cpu_bus_tracer.sv
// cpu_bus_tracer: records 6502 bus cycles into a FIFO and dumps them as ASCII hex to the LCD writer
module cpu_bus_tracer
  import tracer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_L,
  input  logic              phi2_in,
  input  logic [15:0]       extAB,
  input  logic [7:0]        extDB,
  input  logic              RW,
  input  logic              SYNC,
  input  logic              capture_en,
  input  logic              sync_only,
  input  logic              dump_req,
  input  logic              initDone,
  input  logic              writeDone,
  output logic [7:0]        data,
  output logic              writeStart,
  output logic              busy,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);
  state_t state;
  logic sync1, sync2, sync3, rw_q, sync_q;
  logic [15:0] ab_q;
  logic [7:0] db_q;
  logic fall, push, pop, start;
  logic [REC_W-1:0] rec, hold;
  logic [ADDR_W:0] n;
  logic [2:0] k;
  logic [3:0] an, dn;
  logic [7:0] ch;
  assign fall = ~sync2 & sync3;
  assign push = fall & capture_en & (~sync_only | sync_q);
  assign pop = (state == LOAD);
  assign start = (state == IDLE) & dump_req & initDone & ~empty;
  trace_fifo #(.WIDTH(REC_W), .DEPTH(DEPTH)) fifo (
    .clk, .rst_L, .push, .pop,
    .wdata({rw_q, sync_q, ab_q, db_q}),
    .rdata(rec), .full, .empty, .count
  );
  // synchronise phi2 and register the bus so the sampled record is one clk old
  always_ff @(posedge clk)
    if (!rst_L) begin
      {sync1, sync2, sync3} <= '0;
      {rw_q, sync_q, ab_q, db_q} <= '0;
    end else begin
      {sync1, sync2, sync3} <= {phi2_in, sync1, sync2};
      {rw_q, sync_q, ab_q, db_q} <= {RW, SYNC, extAB, extDB};
    end
  // sticky drop flag, cleared only when a dump starts
  always_ff @(posedge clk)
    if (!rst_L) overflow <= 1'b0;
    else overflow <= (overflow & ~start) | (push & full & ~pop);
  // character k of the held record
  always_comb begin
    an = k[1:0] == 2'd0 ? hold[AB_LSB+12+:4] : k[1:0] == 2'd1 ? hold[AB_LSB+8+:4] :
         k[1:0] == 2'd2 ? hold[AB_LSB+4+:4] : hold[AB_LSB+:4];
    dn = k[0] ? hold[DB_LSB+:4] : hold[DB_LSB+4+:4];
    ch = k == 3'd7 ? SP : k == 3'd6 ? (hold[SYNC_BIT] ? S : hold[RW_BIT] ? R : W) :
         nibble_to_ascii(k[2] ? dn : an);
  end
  // dump sequencer: snapshot count, then emit 8 chars per record with writeStart/writeDone
  always_ff @(posedge clk)
    if (!rst_L) begin
      state <= IDLE;
      busy <= 1'b0;
      writeStart <= 1'b0;
      data <= SP;
      n <= '0;
      k <= '0;
      hold <= '0;
    end else begin
      writeStart <= (state == EMIT);
      case (state)
        IDLE: if (start) begin
          n <= count;
          busy <= 1'b1;
          state <= LOAD;
        end
        LOAD: begin
          hold <= rec;
          k <= '0;
          state <= EMIT;
        end
        EMIT: begin
          data <= ch;
          state <= WAIT;
        end
        WAIT: if (writeDone) begin
          k <= k + 3'd1;
          if (k != 3'd7) state <= EMIT;
          else begin
            n <= n - (ADDR_W+1)'(1);
            busy <= n != (ADDR_W+1)'(1);
            state <= n == (ADDR_W+1)'(1) ? IDLE : LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_cpu_bus_tracer.sv
// tb_cpu_bus_tracer: directed self-checking bench for cpu_bus_tracer
module tb_cpu_bus_tracer;
  logic clk = 0, rst_L = 0, phi2_in = 0, RW = 1, SYNC = 0;
  logic capture_en = 1, sync_only = 0, dump_req = 0, initDone = 1, writeDone = 0;
  logic [15:0] extAB = '0;
  logic [7:0] extDB = '0;
  logic [7:0] data;
  logic writeStart, busy, full, empty, overflow;
  logic [4:0] count;
  int tests = 0, fails = 0, nch = 0;
  logic [7:0] cbuf [128];
  always #5 clk = ~clk;
  cpu_bus_tracer #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk, .rst_L, .phi2_in, .extAB, .extDB, .RW, .SYNC, .capture_en, .sync_only,
    .dump_req, .initDone, .writeDone, .data, .writeStart, .busy, .full, .empty,
    .count, .overflow
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic phi2_fall(input logic [15:0] ab, input logic [7:0] db, input logic rw, input logic sy);
    extAB = ab;
    extDB = db;
    RW = rw;
    SYNC = sy;
    phi2_in = 1;
    repeat (4) @(negedge clk);
    phi2_in = 0;
    repeat (6) @(negedge clk);
  endtask
  task automatic wait_ws(output bit ok);
    int t = 0;
    while (!writeStart && t < 40) begin
      @(negedge clk);
      t++;
    end
    ok = writeStart;
  endtask
  task automatic ack();
    repeat (2) @(negedge clk);
    writeDone = 1;
    @(negedge clk);
    writeDone = 0;
  endtask
  task automatic quiet(input int cycles, output int pulses);
    pulses = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (writeStart) pulses++;
    end
  endtask
  task automatic dump(input int nexp);
    bit ok;
    nch = 0;
    dump_req = 1;
    @(negedge clk);
    dump_req = 0;
    for (int i = 0; i < nexp; i++) begin
      wait_ws(ok);
      if (!ok) break;
      cbuf[nch] = data;
      nch++;
      ack();
    end
    chk("nchars", 64'(nch), 64'(nexp));
  endtask
  function automatic logic [63:0] word(input int b);
    logic [63:0] v = '0;
    for (int i = 0; i < 8; i++) v = {v[55:0], cbuf[b+i]};
    return v;
  endfunction
  initial begin
    bit ok;
    int p;
    repeat (3) @(negedge clk);
    rst_L = 1;
    @(negedge clk);
    chk("rst_data", 64'(data), 64'(8'h20));
    chk("rst_ws", 64'(writeStart), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_full", 64'(full), 64'(0));
    chk("rst_empty", 64'(empty), 64'(1));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_ovf", 64'(overflow), 64'(0));
    phi2_fall(16'hC000, 8'hA9, 1, 1);
    phi2_fall(16'hC001, 8'h00, 1, 0);
    phi2_fall(16'hC002, 8'h8D, 1, 1);
    chk("cap3_count", 64'(count), 64'(3));
    chk("cap3_empty", 64'(empty), 64'(0));
    chk("cap3_ovf", 64'(overflow), 64'(0));
    dump(24);
    chk("rec0", word(0), "C000A9S ");
    chk("rec1", word(8), "C00100R ");
    chk("rec2", word(16), "C0028DS ");
    quiet(6, p);
    chk("dump_extra_ws", 64'(p), 64'(0));
    chk("dump_busy", 64'(busy), 64'(0));
    chk("dump_count", 64'(count), 64'(0));
    chk("dump_empty", 64'(empty), 64'(1));
    phi2_fall(16'h0200, 8'h5F, 0, 0);
    dump(8);
    chk("write_rec", word(0), "02005FW ");
    for (int i = 0; i < 18; i++) phi2_fall(16'h1000 + 16'(i), 8'(i), 1, 0);
    chk("ovf_full", 64'(full), 64'(1));
    chk("ovf_count", 64'(count), 64'(16));
    chk("ovf_flag", 64'(overflow), 64'(1));
    dump(128);
    chk("ovf_first", word(0), "100000R ");
    chk("ovf_last", word(120), "100F0FR ");
    chk("ovf_cleared", 64'(overflow), 64'(0));
    chk("ovf_drained", 64'(count), 64'(0));
    sync_only = 1;
    phi2_fall(16'h2000, 8'h11, 1, 1);
    phi2_fall(16'h2001, 8'h22, 1, 0);
    phi2_fall(16'h2002, 8'h33, 1, 0);
    phi2_fall(16'h2003, 8'h44, 1, 1);
    phi2_fall(16'h2004, 8'h55, 1, 0);
    sync_only = 0;
    chk("synconly_count", 64'(count), 64'(2));
    initDone = 0;
    dump_req = 1;
    @(negedge clk);
    dump_req = 0;
    quiet(10, p);
    chk("noinit_ws", 64'(p), 64'(0));
    chk("noinit_busy", 64'(busy), 64'(0));
    chk("noinit_count", 64'(count), 64'(2));
    initDone = 1;
    dump_req = 1;
    @(negedge clk);
    dump_req = 0;
    for (int i = 0; i < 3; i++) begin
      wait_ws(ok);
      chk("mid_ws", 64'(ok), 64'(1));
      ack();
    end
    wait_ws(ok);
    chk("mid_k3_ws", 64'(ok), 64'(1));
    chk("mid_k3_data", 64'(data), 64'(8'h30));
    rst_L = 0;
    @(negedge clk);
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_ws", 64'(writeStart), 64'(0));
    chk("mid_rst_data", 64'(data), 64'(8'h20));
    chk("mid_rst_count", 64'(count), 64'(0));
    rst_L = 1;
    @(negedge clk);
    writeDone = 1;
    @(negedge clk);
    writeDone = 0;
    quiet(8, p);
    chk("post_rst_ws", 64'(p), 64'(0));
    chk("post_rst_busy", 64'(busy), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
